// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared constants for the MEM-stage data-memory controller:
//                FSM state encoding, default abort limit and counter width.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Default number of REQ cycles allowed before an access is abandoned
  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

  // Width of the REQ-cycle counter
  localparam int CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/dmem_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_timeout_cnt
//  Description : Counts REQ cycles that pass without an acknowledge and flags
//                the cycle in which the count reaches LIMIT.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_timeout_cnt
  import dmem_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  // The count holds the number of completed un-acked REQ cycles, so the
  // LIMIT-th such cycle is the one where the count still shows LIMIT-1.
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Restart on entry to REQ, advance on every un-acked REQ cycle
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Only meaningful while enabled, so an ack in the same cycle suppresses it
  assign o_expire = i_en && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_ctrl
//  Description : MEM-stage data-memory access controller. Runs a req/ack
//                handshake to a variable-latency memory, stalls the pipeline
//                while an access is in flight and holds the load result.
//                Optional REQ timeout enabled with macro DMEM_TIMEOUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WData_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] RData_o,
  output logic        Stall_o,
  output logic        Error_o
);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;

  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic        w_access;   // instruction in EX/MEM wants memory
  logic        w_launch;   // start a new access this cycle
  logic        w_in_req;   // handshake in flight
  logic        w_finish;   // handshake ends this cycle (ack or abort)
  logic        w_expire;   // REQ-cycle budget exhausted this cycle

  assign w_access = MemRead_i | MemWrite_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_access) w_state_nxt = REQ;
      REQ:     if (mem_ack_i || w_expire) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State-decoded controls and the pipeline stall
  always_comb begin
    w_launch = (r_state == IDLE) && w_access;
    w_in_req = (r_state == REQ);
    w_finish = w_in_req && (mem_ack_i || w_expire);
    Stall_o  = !rst_i && (w_launch || w_in_req);
  end

  // Memory-side request registers: captured at launch, frozen through REQ
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_launch) begin
      r_req   <= 1'b1;
      r_we    <= MemWrite_i;   // read+write together resolves to a write
      r_addr  <= Addr_i;
      r_wdata <= WData_i;
    end else if (w_finish) begin
      r_req   <= 1'b0;
    end
  end

  // Load result: memory data on ack, zero on an aborted read
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdata <= '0;
    end else if (w_finish && !r_we) begin
      r_rdata <= mem_ack_i ? mem_rdata_i : 32'd0;
    end
  end

`ifdef DMEM_TIMEOUT_EN
  logic w_timeout;
  logic r_error;

  dmem_timeout_cnt #(
    .LIMIT    (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk      (clk_i),
    .rst      (rst_i),
    .i_clr    (w_launch),
    .i_en     (w_in_req && !mem_ack_i),
    .o_expire (w_expire)
  );

  // An ack arriving with the expiry wins, so only an un-acked expiry aborts
  assign w_timeout = w_in_req && !mem_ack_i && w_expire;

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_error <= 1'b0;
    end else if (w_timeout) begin
      r_error <= 1'b1;
    end
  end

  assign Error_o = r_error;
`else
  logic w_unused_timeout;

  // Without the timeout REQ waits for ack indefinitely
  assign w_expire         = 1'b0;
  assign Error_o          = 1'b0;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign RData_o     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_ctrl
//  Description : Self-checking bench for dmem_ctrl: transaction-level model
//                compared every cycle, plus directed literal expectations.
//                Timeout scenarios run when DMEM_TIMEOUT_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_ctrl;

  localparam int TO = 4;
`ifdef DMEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        MemRead_i = 1'b0;
  logic        MemWrite_i = 1'b0;
  logic [31:0] Addr_i = '0;
  logic [31:0] WData_i = '0;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic [31:0] RData_o;
  logic        Stall_o;
  logic        Error_o;

  int checks = 0;
  int errors = 0;
  int stall_total = 0;
  bit started = 1'b0;

  dmem_ctrl #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .Addr_i      (Addr_i),
    .WData_i     (WData_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .RData_o     (RData_o),
    .Stall_o     (Stall_o),
    .Error_o     (Error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    check(nm, {31'd0, act}, {31'd0, exp});
  endtask

  // ---------------- transaction-level model ----------------
  // An access is: issued (one stall cycle), outstanding for as many cycles as
  // memory takes (each stalls), then one non-stalled completion cycle.
  bit          m_busy = 0;
  bit          m_done = 0;
  int          m_waited = 0;
  logic        m_we = 0;
  logic [31:0] m_addr = 0;
  logic [31:0] m_wdata = 0;
  logic [31:0] m_rdata = 0;
  logic        m_err = 0;

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_busy = 0; m_done = 0; m_waited = 0;
      m_we = 0; m_addr = 0; m_wdata = 0; m_rdata = 0; m_err = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      if (mem_ack_i) begin
        m_busy = 0; m_done = 1;
        if (!m_we) m_rdata = mem_rdata_i;
      end else if (TO_EN && (m_waited + 1 == TO)) begin
        m_busy = 0; m_done = 1; m_err = 1;
        if (!m_we) m_rdata = 0;
      end else begin
        m_waited++;
      end
    end else if (MemRead_i || MemWrite_i) begin
      m_busy = 1; m_waited = 0;
      m_we = MemWrite_i; m_addr = Addr_i; m_wdata = WData_i;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk_i) begin
    if (started) begin
      check1("req",   mem_req_o, m_busy);
      check1("stall", Stall_o,
             !rst_i && (m_busy || (!m_done && (MemRead_i || MemWrite_i))));
      check1("err",   Error_o, m_err);
      check("rdata",  RData_o, m_rdata);
      if (m_busy) begin
        check1("we",    mem_we_o, m_we);
        check("addr",   mem_addr_o, m_addr);
        check("wdata",  mem_wdata_o, m_wdata);
      end
      if (Stall_o) stall_total++;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One access presented in an IDLE cycle; returns in the IDLE cycle after DONE
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input int waits,
                        input logic [31:0] rdat, input logic [31:0] exp_rdata,
                        input int exp_stall);
    int s0;
    s0 = stall_total;
    MemRead_i = rd; MemWrite_i = wr; Addr_i = a; WData_i = d;
    #1;
    check1("issue_stall", Stall_o, 1'b1);
    tick();
    for (int w = 0; w <= waits; w++) begin
      check1("req_up",   mem_req_o, 1'b1);
      check1("req_we",   mem_we_o, wr);
      check("req_addr",  mem_addr_o, a);
      check("req_wdata", mem_wdata_o, d);
      mem_ack_i   = (w == waits);
      mem_rdata_i = rdat;
      tick();
    end
    mem_ack_i = 1'b0;
    check1("done_req", mem_req_o, 1'b0);
    check("done_rdata", RData_o, exp_rdata);
    tick();
    check("stall_len", stall_total - s0, exp_stall);
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic to_access(input logic ack4, input logic [31:0] rdat,
                           input logic [31:0] exp_rdata);
    int s0;
    s0 = stall_total;
    MemRead_i = 1'b1; MemWrite_i = 1'b0; Addr_i = 32'h300;
    tick();
    for (int i = 0; i < 4; i++) begin
      check1("to_req_up", mem_req_o, 1'b1);
      mem_ack_i   = ack4 && (i == 3);
      mem_rdata_i = rdat;
      tick();
    end
    mem_ack_i = 1'b0;
    check1("to_req_drop", mem_req_o, 1'b0);
    check1("to_error", Error_o, !ack4);
    check("to_rdata", RData_o, exp_rdata);
    MemRead_i = 1'b0;
    tick();
    check("to_stall_len", stall_total - s0, 5);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held two cycles with a load pending
    rst_i = 1'b1; MemRead_i = 1'b1; Addr_i = 32'h100;
    tick();
    started = 1'b1;
    tick();
    check1("rst_req",   mem_req_o, 1'b0);
    check1("rst_we",    mem_we_o, 1'b0);
    check("rst_addr",   mem_addr_o, 32'h0);
    check("rst_wdata",  mem_wdata_o, 32'h0);
    check("rst_rdata",  RData_o, 32'h0);
    check1("rst_stall", Stall_o, 1'b0);
    check1("rst_err",   Error_o, 1'b0);
    rst_i = 1'b0;

    // Zero-wait load
    access(1'b1, 1'b0, 32'h100, 32'h0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 2);
    // Three-wait store leaves the load result alone
    access(1'b0, 1'b1, 32'h40, 32'h12345678, 3, 32'hFFFF0000, 32'hCAFEF00D, 5);
    // Read+write together is a write; then an immediately following load
    access(1'b1, 1'b1, 32'h80, 32'hA5A5A5A5, 1, 32'h11111111, 32'hCAFEF00D, 3);
    access(1'b1, 1'b0, 32'h84, 32'h0, 2, 32'h0BADCAFE, 32'h0BADCAFE, 4);
    MemRead_i = 1'b0; MemWrite_i = 1'b0;
    tick();

`ifdef DMEM_TIMEOUT_EN
    // Abort after the REQ budget, then sticky error until reset
    to_access(1'b0, 32'h99999999, 32'h0);
    tick(); tick();
    check1("err_sticky", Error_o, 1'b1);
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    check1("err_cleared", Error_o, 1'b0);
    // Ack on the last allowed cycle wins over the timeout
    to_access(1'b1, 32'h55AA55AA, 32'h55AA55AA);
`endif

    // Reset on the second wait cycle of a load abandons it
    MemRead_i = 1'b1; Addr_i = 32'h200;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    check1("abort_req", mem_req_o, 1'b0);
    check1("abort_stall", Stall_o, 1'b0);
    rst_i = 1'b0; MemRead_i = 1'b0;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h77777777;
    tick(); tick();
    check1("late_ack_req", mem_req_o, 1'b0);
    check("late_ack_rdata", RData_o, 32'h0);
    mem_ack_i = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
